// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the ALU operand-select path: buffer state encoding
// and the symbolic operand-source indices.
package cpu_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

  localparam int SRC_PC       = 0;
  localparam int SRC_A        = 1;
  localparam int SRC_IMM      = 2;
  localparam int SRC_IMM_SHL2 = 3;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output/skid buffer with a registered in_ready, so that out_ready
// never reaches the upstream handshake through combinational logic.
module skid_buf2
  import cpu_mux_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state_reg;
  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      out_reg       <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            out_reg       <= in_data;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            // Downstream stalled: park the new word behind the output word.
            skid_reg     <= in_data;
            in_ready_reg <= 1'b0;
            state_reg    <= FULL;
          end else if (out_xfer && !in_xfer) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end else if (in_xfer && out_xfer) begin
            out_reg <= in_data;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_reg      <= skid_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= ONE;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_reg;

endmodule

// File: rtl/alu_src_mux_pipe.sv
// ALU operand source select with a one-cycle registered output stage and a
// skid entry; out-of-range selects yield zero with an error flag.
module alu_src_mux_pipe
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int N_SLOT = 1 << SEL_W;

  // Pad the source table to every encodable select so indexing stays in range.
  logic [WIDTH-1:0] src_arr [N_SLOT];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_real
        assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign src_arr[gi] = '0;
      end
    end
  endgenerate

  logic             sel_err;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH:0]   buf_in;
  logic [WIDTH:0]   buf_out;

  always_comb begin
    sel_err  = (32'(sel) >= 32'(NUM_SRC));
    sel_data = sel_err ? '0 : src_arr[sel];
    buf_in   = {sel_err, sel_data};
  end

  skid_buf2 #(
    .W(WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_data  (buf_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (buf_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data    = buf_out[WIDTH-1:0];
  assign out_sel_err = buf_out[WIDTH];

endmodule
